// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the basic-computer control path: opcodes, ALU
// operations, AR source select and the bundled control word.
package control_sequencer_pkg;

    localparam int unsigned NUM_PHASES = 5;
    localparam int unsigned MIRROR_W   = 3;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_REG = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_LDA = 3'd0,
        ALU_AND = 3'd1,
        ALU_ADD = 3'd2,
        ALU_CLA = 3'd3,
        ALU_CMA = 3'd4,
        ALU_INC = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        AR_SRC_PC  = 2'd0,
        AR_SRC_IR  = 2'd1,
        AR_SRC_MEM = 2'd2
    } ar_src_e;

    // Instruction word as latched from memory
    typedef struct packed {
        logic        indirect;
        opcode_e     op;
        logic [11:0] addr;
    } instr_t;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic    ar_ld;
        ar_src_e ar_src;
        logic    mem_rd;
        logic    mem_wr;
        logic    ir_ld;
        logic    pc_inc;
        logic    pc_ld;
        logic    ac_ld;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'('0);

    // ALU function for the memory-operand instructions that load AC
    function automatic alu_op_e mem_alu_op(input opcode_e op);
        case (op)
            OP_AND:  return ALU_AND;
            OP_ADD:  return ALU_ADD;
            default: return ALU_LDA;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the timing generator / datapath (master) and the control
// sequencer (slave): phase strobes and memory data in, control lines out.
interface control_sequencer_if;
    logic        T0;
    logic        T1;
    logic        T2;
    logic        T3;
    logic        T4;
    logic [15:0] ir_in;
    logic        ar_ld;
    logic [1:0]  ar_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_ld;
    logic        pc_inc;
    logic        pc_ld;
    logic        ac_ld;
    logic [2:0]  alu_op;
    logic        halted;
    logic        fault;

    modport master (
        output T0, T1, T2, T3, T4, ir_in,
        input  ar_ld, ar_src, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, ac_ld,
        input  alu_op, halted, fault
    );

    modport slave (
        input  T0, T1, T2, T3, T4, ir_in,
        output ar_ld, ar_src, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, ac_ld,
        output alu_op, halted, fault
    );
endinterface

// File: rtl/control_sequencer_phase_checker.sv
// Local copy of the timing generator's phase count. Flags any cycle where
// the incoming T strobes differ from the one-hot pattern the count implies,
// and passes through only the strobe that agrees with the count.
module control_sequencer_phase_checker
    import control_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [NUM_PHASES-1:0] t_strobe_i,
    output logic [NUM_PHASES-1:0] phase_hit_o,
    output logic                  phase_err_o
);

    logic [MIRROR_W-1:0]   mirror_q;
    logic [MIRROR_W-1:0]   mirror_d;
    logic [NUM_PHASES-1:0] expected;

    // Free-running 3-bit count, wraps 7 -> 0; 5..7 are the dead cycles
    always_ff @(posedge clk or posedge Reset) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (Reset) begin
            mirror_q <= '0;
        end else begin
            mirror_q <= mirror_d;
        end
    end

    // Expected one-hot strobe pattern for the current count
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        expected = '0;
        mirror_d = mirror_q + 3'd1;
        if (mirror_q < 3'(NUM_PHASES)) begin
            expected[mirror_q] = 1'b1;
        end
    end

    assign phase_err_o = (t_strobe_i != expected);
    assign phase_hit_o = t_strobe_i & expected;

endmodule

// File: rtl/control_sequencer.sv
// Instruction-cycle control sequencer: decodes the latched instruction
// against the current phase strobe and drives the datapath controls.
// A phase mismatch or illegal opcode latches fault; HLT latches halted;
// either one silences every control until Reset.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    control_sequencer_if.slave bus
);

    logic [NUM_PHASES-1:0] t_strobe;
    logic [NUM_PHASES-1:0] phase_hit;
    logic                  phase_err;

    logic [15:0] ir_q;
    logic [15:0] ir_d;
    logic        halted_q;
    logic        halted_d;
    logic        fault_q;
    logic        fault_d;

    instr_t instr;
    logic   active;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   set_halt;
    logic   set_illegal;
    logic   unused_addr_bits;

    assign t_strobe = {bus.T4, bus.T3, bus.T2, bus.T1, bus.T0};

    control_sequencer_phase_checker u_phase_checker (
        .clk         (clk),
        .Reset       (Reset),
        .t_strobe_i  (t_strobe),
        .phase_hit_o (phase_hit),
        .phase_err_o (phase_err)
    );

    assign instr            = instr_t'(ir_q);
    assign active           = ~(halted_q | fault_q);
    assign unused_addr_bits = ^instr.addr[8:1];

    // State register: instruction latch and sticky status flags
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ir_q     <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Next state: IR loads only on a valid T1; flags only ever set
    always_comb begin
        ir_d = ir_q;
        if (active && phase_hit[1]) begin
            ir_d = bus.ir_in;
        end
        halted_d = halted_q | set_halt;
        fault_d  = fault_q | phase_err | set_illegal;
    end

    // Output decode from the agreeing strobe and the latched instruction
    always_comb begin
        ctrl        = CTRL_IDLE;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        if (active) begin
            if (phase_hit[0]) begin
                ctrl.ar_ld  = 1'b1;
                ctrl.ar_src = AR_SRC_PC;
            end
            if (phase_hit[1]) begin
                ctrl.mem_rd = 1'b1;
                ctrl.ir_ld  = 1'b1;
                ctrl.pc_inc = 1'b1;
            end
            if (phase_hit[2]) begin
                ctrl.ar_ld  = 1'b1;
                ctrl.ar_src = AR_SRC_IR;
                set_illegal = (instr.op == OP_BSA) || (instr.op == OP_ISZ) ||
                              ((instr.op == OP_REG) && instr.indirect);
            end
            if (phase_hit[3]) begin
                if ((instr.op <= OP_BUN) && instr.indirect) begin
                    ctrl.mem_rd = 1'b1;
                    ctrl.ar_ld  = 1'b1;
                    ctrl.ar_src = AR_SRC_MEM;
                end else if ((instr.op == OP_REG) && !instr.indirect) begin
                    if (instr.addr[11]) begin
                        ctrl.ac_ld  = 1'b1;
                        ctrl.alu_op = ALU_CLA;
                    end else if (instr.addr[10]) begin
                        ctrl.ac_ld  = 1'b1;
                        ctrl.alu_op = ALU_CMA;
                    end else if (instr.addr[9]) begin
                        ctrl.ac_ld  = 1'b1;
                        ctrl.alu_op = ALU_INC;
                    end else if (instr.addr[0]) begin
                        set_halt = 1'b1;
                    end
                end
            end
            if (phase_hit[4]) begin
                case (instr.op)
                    OP_AND, OP_ADD, OP_LDA: begin
                        ctrl.mem_rd = 1'b1;
                        ctrl.ac_ld  = 1'b1;
                        ctrl.alu_op = mem_alu_op(instr.op);
                    end
                    OP_STA:  ctrl.mem_wr = 1'b1;
                    OP_BUN:  ctrl.pc_ld  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Reset forces the control lines low immediately, independent of clk
    always_comb begin
        ctrl_out = Reset ? CTRL_IDLE : ctrl;
    end

    assign bus.ar_ld  = ctrl_out.ar_ld;
    assign bus.ar_src = ctrl_out.ar_src;
    assign bus.mem_rd = ctrl_out.mem_rd;
    assign bus.mem_wr = ctrl_out.mem_wr;
    assign bus.ir_ld  = ctrl_out.ir_ld;
    assign bus.pc_inc = ctrl_out.pc_inc;
    assign bus.pc_ld  = ctrl_out.pc_ld;
    assign bus.ac_ld  = ctrl_out.ac_ld;
    assign bus.alu_op = ctrl_out.alu_op;
    assign bus.halted = halted_q;
    assign bus.fault  = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. A behavioural model tracks the
// phase count, the fetched instruction and the two status flags, and derives
// each cycle's expected control word straight from the instruction rules.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic Reset;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int          m_phase;
    logic [15:0] m_ir;
    bit          m_halted;
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dut_ctrl();
        return {bus.ar_ld, bus.ar_src, bus.mem_rd, bus.mem_wr, bus.ir_ld,
                bus.pc_inc, bus.pc_ld, bus.ac_ld, bus.alu_op};
    endfunction

    function automatic logic [4:0] good_t(input int phase);
        logic [4:0] v = '0;
        if (phase < 5) v[phase] = 1'b1;
        return v;
    endfunction

    function automatic bit model_strobe_ok(input logic [4:0] t);
        return !m_halted && !m_fault && (m_phase < 5) && t[m_phase];
    endfunction

    // Expected control word for this cycle, from the instruction rules
    function automatic logic [11:0] model_ctrl(input logic [4:0] t);
        int ar_ld = 0, src = 0, rd = 0, wr = 0, irl = 0, inc = 0, pcl = 0, acl = 0, alu = 0;
        int op = int'(m_ir[14:12]);
        bit ind = m_ir[15];
        int load_alu[3] = '{1, 2, 0};
        if (model_strobe_ok(t)) begin
            case (m_phase)
                0: ar_ld = 1;
                1: begin rd = 1; irl = 1; inc = 1; end
                2: begin ar_ld = 1; src = 1; end
                3: begin
                    if (op <= 4 && ind) begin
                        rd = 1; ar_ld = 1; src = 2;
                    end else if (op == 7 && !ind) begin
                        if (m_ir[11])      begin acl = 1; alu = 3; end
                        else if (m_ir[10]) begin acl = 1; alu = 4; end
                        else if (m_ir[9])  begin acl = 1; alu = 5; end
                    end
                end
                4: begin
                    if (op <= 2) begin rd = 1; acl = 1; alu = load_alu[op]; end
                    else if (op == 3) wr = 1;
                    else if (op == 4) pcl = 1;
                end
                default: ;
            endcase
        end
        return {ar_ld[0], src[1:0], rd[0], wr[0], irl[0], inc[0], pcl[0], acl[0], alu[2:0]};
    endfunction

    // Model state update at a clock edge
    task automatic model_edge(input logic [4:0] t, input logic [15:0] ir);
        int op = int'(m_ir[14:12]);
        bit ind = m_ir[15];
        if (model_strobe_ok(t)) begin
            if (m_phase == 1) m_ir = ir;
            if (m_phase == 2 && (op == 5 || op == 6 || (op == 7 && ind))) m_fault = 1;
            if (m_phase == 3 && op == 7 && !ind && m_ir[11:9] == 3'b000 && m_ir[0]) m_halted = 1;
        end
        if (t != good_t(m_phase)) m_fault = 1;
        m_phase = (m_phase + 1) % 8;
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_ir     = '0;
        m_halted = 0;
        m_fault  = 0;
    endtask

    // One clock cycle: drive just after an edge, check before the next
    task automatic step(input logic [4:0] t, input logic [15:0] ir, input string tag);
        {bus.T4, bus.T3, bus.T2, bus.T1, bus.T0} = t;
        bus.ir_in = ir;
        #3;
        check({tag, "/ctrl"}, 32'(dut_ctrl()), 32'(model_ctrl(t)));
        check({tag, "/halted"}, 32'(bus.halted), 32'(m_halted));
        check({tag, "/fault"}, 32'(bus.fault), 32'(m_fault));
        @(posedge clk);
        model_edge(t, ir);
        #1;
    endtask

    // Eight cycles of one instruction; ir_in carries noise outside T1
    task automatic run_instr(input logic [15:0] instr, input string tag, input bit glitch);
        for (int k = 0; k < 8; k++) begin
            logic [4:0]  t  = good_t(m_phase);
            logic [15:0] ir = (m_phase == 1) ? instr : 16'($urandom);
            if (glitch && $urandom_range(0, 7) == 0) t ^= 5'(1 << $urandom_range(0, 4));
            step(t, ir, tag);
        end
    endtask

    task automatic apply_reset(input string tag);
        Reset = 1'b1;
        #1;
        check({tag, "/rst_ctrl"}, 32'(dut_ctrl()), 32'h0);
        check({tag, "/rst_halted"}, 32'(bus.halted), 32'h0);
        check({tag, "/rst_fault"}, 32'(bus.fault), 32'h0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        Reset = 1'b1;
        {bus.T4, bus.T3, bus.T2, bus.T1, bus.T0} = 5'b00001;
        bus.ir_in = 16'hFFFF;
        #2;
        check("por/ctrl", 32'(dut_ctrl()), 32'h0);
        check("por/halted", 32'(bus.halted), 32'h0);
        check("por/fault", 32'(bus.fault), 32'h0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        model_reset();

        // ADD direct, LDA indirect
        run_instr(16'h1123, "add", 1'b0);
        check("add/fault_clear", 32'(bus.fault), 32'h0);
        run_instr(16'hA345, "lda_ind", 1'b0);
        run_instr(16'h8345, "and_ind", 1'b0);
        run_instr(16'h3010, "sta", 1'b0);
        run_instr(16'h4020, "bun", 1'b0);

        // HLT, then silence, then Reset clears it
        run_instr(16'h7001, "hlt", 1'b0);
        check("hlt/halted", 32'(bus.halted), 32'h1);
        run_instr(16'h1123, "after_hlt", 1'b0);
        apply_reset("hlt");

        // Wrong strobe in phase 1: fault is sticky across 16 cycles
        step(good_t(m_phase), 16'h0, "perr_t0");
        step(5'b00100, 16'h1123, "perr_bad");
        check("perr/fault", 32'(bus.fault), 32'h1);
        for (int k = 0; k < 16; k++) step(good_t(m_phase), 16'($urandom), "perr_hold");
        check("perr/sticky", 32'(bus.fault), 32'h1);
        apply_reset("perr");

        // Illegal opcode, register-reference priority
        run_instr(16'h5000, "op5", 1'b0);
        check("op5/fault", 32'(bus.fault), 32'h1);
        apply_reset("op5");
        run_instr(16'h7C00, "cla", 1'b0);
        run_instr(16'h7400, "cma", 1'b0);
        run_instr(16'h7201, "inc", 1'b0);
        run_instr(16'h7000, "nop", 1'b0);

        // Stray strobe in a dead cycle
        for (int k = 0; k < 6; k++) step(good_t(m_phase), 16'h1123, "dead_pre");
        step(5'b00001, 16'h0, "dead_bad");
        check("dead/fault", 32'(bus.fault), 32'h1);
        apply_reset("dead");

        // Fault and HLT on the same edge
        for (int k = 0; k < 3; k++) step(good_t(m_phase), (k == 1) ? 16'h7001 : 16'h0, "hf");
        step(5'b11000, 16'h0, "hf_t3");
        check("hf/halted", 32'(bus.halted), 32'h1);
        check("hf/fault", 32'(bus.fault), 32'h1);
        apply_reset("hf");

        // Asynchronous Reset in T3 of an indirect fetch
        for (int k = 0; k < 3; k++) step(good_t(m_phase), (k == 1) ? 16'hA345 : 16'($urandom), "arst");
        {bus.T4, bus.T3, bus.T2, bus.T1, bus.T0} = 5'b01000;
        #2;
        check("arst/t3_ctrl", 32'(dut_ctrl()), 32'(model_ctrl(5'b01000)));
        #1;
        Reset = 1'b1;
        #1;
        check("arst/ctrl_now", 32'(dut_ctrl()), 32'h0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        model_reset();
        step(good_t(m_phase), 16'h0, "arst_t0");

        // Randomised instruction stream with occasional strobe glitches
        for (int n = 0; n < 60; n++) begin
            logic [15:0] instr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                instr[15:12] = 4'h7;
                instr[11:9]  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            end
            run_instr(instr, "rnd", ($urandom_range(0, 3) == 0));
            if (m_halted || m_fault) apply_reset("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
